// File: rtl/zorro3_autoconfig_multi.sv
// Zorro III AutoConfig controller offering 1..4 logical boards in sequence behind one
// CFGIN_n/CFGOUT_n pair, then decoding each configured base into a per-board select.
module zorro3_autoconfig_multi #(
  parameter int                        NUM_BOARDS = 2,
  parameter logic [15:0]               MFG_ID     = 16'h07DB,
  parameter logic [31:0]               SERIAL     = 32'd421,
  parameter logic [8*NUM_BOARDS-1:0]   PROD_IDS   = {8'h73, 8'h72},
  parameter logic [3*NUM_BOARDS-1:0]   SIZE_CODES = {3'b100, 3'b100},
  parameter logic [NUM_BOARDS-1:0]     MEMLIST    = 2'b11
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic                  cfg_space,
  input  logic [7:0]            ADDRH,
  input  logic [6:0]            ADDRL,
  input  logic                  FCS_n,
  input  logic                  DS_n,
  input  logic                  READ,
  input  logic [2:0]            FC,
  input  logic                  CFGIN_n,
  input  logic [7:0]            DIN,
  output logic [3:0]            DOUT,
  output logic                  CFGOUT_n,
  output logic                  autoconfig_cycle,
  output logic [NUM_BOARDS-1:0] board_sel,
  output logic                  ram_cycle,
  output logic [NUM_BOARDS-1:0] configured,
  output logic [1:0]            cur_board
);

  // Parameters padded to four boards so a 2-bit index never selects out of range.
  localparam logic [31:0] PROD_PAD = 32'(PROD_IDS);
  localparam logic [11:0] SIZE_PAD = 12'(SIZE_CODES);
  localparam logic [3:0]  MEM_PAD  = 4'(MEMLIST);
  localparam logic [2:0]  NB3      = 3'(NUM_BOARDS);
  localparam logic [1:0]  LAST     = 2'(NUM_BOARDS - 1);

  logic [1:0]            vs_q;
  logic [2:0]            cnt_q, cnt_d;
  logic [NUM_BOARDS-1:0] cfgd_q, cfgd_d, shut_q, shut_d;
  logic [7:0]            base_q [NUM_BOARDS];
  logic [7:0]            base_d [NUM_BOARDS];
  logic                  wr_done_q, wr_done_d;
  logic [3:0]            dout_q, dout_d;
  logic                  cfgout_q;
  logic                  all_done, ac, rd_stb, wr_stb;
  logic [1:0]            brd;
  logic [6:0]            idx;
  logic [NUM_BOARDS-1:0] sel_c;
  logic                  unused_fc;

  function automatic logic [3:0] rom_nib(input logic [6:0] i, input logic [1:0] bi);
    logic [7:0] prod;
    logic [2:0] sz;
    logic       chain;
    int         off;
    prod    = PROD_PAD[8*bi +: 8];
    sz      = SIZE_PAD[3*bi +: 3];
    chain   = (bi != LAST);
    rom_nib = 4'hF;
    if (i == 7'h00)      rom_nib = {2'b10, MEM_PAD[bi], 1'b0};
    else if (i == 7'h01) rom_nib = {chain, sz};
    else if (i == 7'h02) rom_nib = ~prod[7:4];
    else if (i == 7'h03) rom_nib = ~prod[3:0];
    else if (i == 7'h04) rom_nib = ~4'b1011;
    else if (i == 7'h05) rom_nib = ~4'b0001;
    else if (i >= 7'h08 && i <= 7'h0B) begin
      off     = 11 - int'(i);
      rom_nib = ~MFG_ID[4*off +: 4];
    end else if (i >= 7'h0C && i <= 7'h13) begin
      off     = 19 - int'(i);
      rom_nib = ~SERIAL[4*off +: 4];
    end else if (i == 7'h20 || i == 7'h21) rom_nib = 4'h0;
  endfunction

  assign unused_fc        = FC[2];
  assign all_done         = (cnt_q >= NB3);
  assign brd              = all_done ? 2'd0 : cnt_q[1:0];
  assign idx              = {ADDRL[5:0], ADDRL[6]};
  assign ac               = cfg_space & ~CFGIN_n & ~all_done & vs_q[1];
  assign rd_stb           = ac & ~FCS_n & READ;
  assign wr_stb           = ac & ~FCS_n & ~READ & ~DS_n & ~wr_done_q;
  assign autoconfig_cycle = ac;

  always_comb begin
    cnt_d     = cnt_q;
    cfgd_d    = cfgd_q;
    shut_d    = shut_q;
    base_d    = base_q;
    wr_done_d = wr_done_q;
    if (FCS_n) wr_done_d = 1'b0;
    if (wr_stb) begin
      wr_done_d = 1'b1;
      for (int b = 0; b < NUM_BOARDS; b++) begin
        if (b == int'(brd)) begin
          if (ADDRL[5:0] == 6'h11) begin
            base_d[b] = DIN;
            cfgd_d[b] = 1'b1;
          end else if (ADDRL[5:0] == 6'h13) begin
            shut_d[b] = 1'b1;
          end
        end
      end
      if (ADDRL[5:0] == 6'h11 || ADDRL[5:0] == 6'h13) cnt_d = cnt_q + 3'd1;
    end
    dout_d = rd_stb ? rom_nib(idx, brd) : dout_q;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      vs_q      <= 2'b00;
      cnt_q     <= 3'd0;
      cfgd_q    <= '0;
      shut_q    <= '0;
      wr_done_q <= 1'b0;
      dout_q    <= 4'h0;
      for (int b = 0; b < NUM_BOARDS; b++) base_q[b] <= 8'hFF;
    end else begin
      vs_q      <= {vs_q[0], FC[1] ^ FC[0]};
      cnt_q     <= cnt_d;
      cfgd_q    <= cfgd_d;
      shut_q    <= shut_d;
      wr_done_q <= wr_done_d;
      dout_q    <= dout_d;
      base_q    <= base_d;
    end
  end

  // Chain output only changes at the end of a bus cycle.
  always_ff @(posedge FCS_n or negedge RESET_n) begin
    if (!RESET_n) cfgout_q <= 1'b1;
    else          cfgout_q <= ~all_done;
  end

  always_comb begin
    logic       found;
    logic [7:0] msk;
    sel_c = '0;
    found = 1'b0;
    for (int b = 0; b < NUM_BOARDS; b++) begin
      msk = 8'hFF << SIZE_PAD[3*b +: 3];
      if (!found && cfgd_q[b] && !shut_q[b] && vs_q[1] && !cfg_space &&
          (((ADDRH ^ base_q[b]) & msk) == 8'h00)) begin
        sel_c[b] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign board_sel  = sel_c;
  assign ram_cycle  = |sel_c;
  assign configured = cfgd_q;
  assign cur_board  = cnt_q[1:0];
  assign DOUT       = dout_q;
  assign CFGOUT_n   = cfgout_q;

endmodule

// File: tb/tb_zorro3_autoconfig_multi.sv
// Directed bench for zorro3_autoconfig_multi: ROM table for board 0 plus hand-written
// configure / shut-up / reset / decode sequences with the default two-board parameters.
module tb_zorro3_autoconfig_multi;

  logic       CLK = 1'b0;
  logic       RESET_n;
  logic       cfg_space;
  logic [7:0] ADDRH;
  logic [6:0] ADDRL;
  logic       FCS_n, DS_n, READ, CFGIN_n;
  logic [2:0] FC;
  logic [7:0] DIN;
  logic [3:0] DOUT;
  logic       CFGOUT_n, autoconfig_cycle, ram_cycle;
  logic [1:0] board_sel, configured, cur_board;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] idx;
    logic [3:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [19];

  zorro3_autoconfig_multi dut (
    .CLK(CLK), .RESET_n(RESET_n), .cfg_space(cfg_space), .ADDRH(ADDRH), .ADDRL(ADDRL),
    .FCS_n(FCS_n), .DS_n(DS_n), .READ(READ), .FC(FC), .CFGIN_n(CFGIN_n), .DIN(DIN),
    .DOUT(DOUT), .CFGOUT_n(CFGOUT_n), .autoconfig_cycle(autoconfig_cycle),
    .board_sel(board_sel), .ram_cycle(ram_cycle), .configured(configured),
    .cur_board(cur_board)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [6:0] i, output logic [3:0] d, output logic a);
    @(negedge CLK);
    cfg_space = 1'b1;
    ADDRL     = {i[0], i[6:1]};
    READ      = 1'b1;
    FCS_n     = 1'b0;
    @(posedge CLK);
    #1;
    d = DOUT;
    a = autoconfig_cycle;
    @(negedge CLK);
    FCS_n = 1'b1;
    @(posedge CLK);
  endtask

  task automatic wr_begin(input logic [5:0] off, input logic [7:0] d, input int ds_clks);
    @(negedge CLK);
    cfg_space = 1'b1;
    ADDRL     = {1'b0, off};
    READ      = 1'b0;
    DIN       = d;
    FCS_n     = 1'b0;
    DS_n      = 1'b1;
    @(negedge CLK);
    DS_n = 1'b0;
    repeat (ds_clks) @(posedge CLK);
    #1;
  endtask

  task automatic wr_end();
    @(negedge CLK);
    DS_n  = 1'b1;
    FCS_n = 1'b1;
    READ  = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [5:0] off, input logic [7:0] d, input int ds_clks);
    wr_begin(off, d, ds_clks);
    wr_end();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_n = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic decode(input logic [7:0] a, input logic [1:0] exp_sel, input string name);
    @(negedge CLK);
    cfg_space = 1'b0;
    ADDRH     = a;
    #1;
    chk(name, {30'd0, board_sel}, {30'd0, exp_sel});
    chk({name, "_ram"}, {31'd0, ram_cycle}, {31'd0, |exp_sel});
  endtask

  logic [3:0] d;
  logic       a;

  initial begin
    vecs[0]  = '{7'h00, 4'hA};  vecs[1]  = '{7'h01, 4'hC};
    vecs[2]  = '{7'h02, 4'h8};  vecs[3]  = '{7'h03, 4'hD};
    vecs[4]  = '{7'h04, 4'h4};  vecs[5]  = '{7'h05, 4'hE};
    vecs[6]  = '{7'h08, 4'hF};  vecs[7]  = '{7'h09, 4'h8};
    vecs[8]  = '{7'h0A, 4'h2};  vecs[9]  = '{7'h0B, 4'h4};
    vecs[10] = '{7'h0C, 4'hF};  vecs[11] = '{7'h10, 4'hF};
    vecs[12] = '{7'h11, 4'hE};  vecs[13] = '{7'h12, 4'h5};
    vecs[14] = '{7'h13, 4'hA};  vecs[15] = '{7'h20, 4'h0};
    vecs[16] = '{7'h21, 4'h0};  vecs[17] = '{7'h06, 4'hF};
    vecs[18] = '{7'h7F, 4'hF};

    RESET_n = 1'b0; cfg_space = 1'b0; ADDRH = 8'h00; ADDRL = 7'h00;
    FCS_n = 1'b1; DS_n = 1'b1; READ = 1'b1; FC = 3'b001; CFGIN_n = 1'b0; DIN = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_dout", {28'd0, DOUT}, 32'h0);
    chk("rst_cfgout", {31'd0, CFGOUT_n}, 32'h1);
    chk("rst_configured", {30'd0, configured}, 32'h0);
    chk("rst_cur_board", {30'd0, cur_board}, 32'h0);
    chk("rst_board_sel", {30'd0, board_sel}, 32'h0);
    chk("rst_ram_cycle", {31'd0, ram_cycle}, 32'h0);
    @(negedge CLK);
    RESET_n = 1'b1;
    repeat (3) @(posedge CLK);

    // Board 0 config ROM.
    for (int k = 0; k < 19; k++) begin
      rd(vecs[k].idx, d, a);
      chk($sformatf("rom_b0_idx%02h", vecs[k].idx), {28'd0, d}, {28'd0, vecs[k].exp});
    end
    chk("b0_cfgout_high", {31'd0, CFGOUT_n}, 32'h1);

    // Chain input high: no claim, no state change.
    rd(7'h00, d, a);
    CFGIN_n = 1'b1;
    rd(7'h01, d, a);
    chk("cfgin_hi_ac", {31'd0, a}, 32'h0);
    chk("cfgin_hi_dout_hold", {28'd0, d}, 32'hA);
    wr(6'h11, 8'h40, 1);
    chk("cfgin_hi_configured", {30'd0, configured}, 32'h0);
    chk("cfgin_hi_cur", {30'd0, cur_board}, 32'h0);
    CFGIN_n = 1'b0;

    // Configure board 0 at 0x40, then board 1 is offered.
    wr(6'h11, 8'h40, 1);
    chk("cfg0_cur", {30'd0, cur_board}, 32'h1);
    chk("cfg0_configured", {30'd0, configured}, 32'h1);
    chk("cfg0_cfgout", {31'd0, CFGOUT_n}, 32'h1);
    rd(7'h01, d, a);
    chk("b1_idx01", {28'd0, d}, 32'h4);
    rd(7'h00, d, a);
    chk("b1_idx00", {28'd0, d}, 32'hA);
    rd(7'h03, d, a);
    chk("b1_idx03", {28'd0, d}, 32'hC);

    // Configure board 1 at 0x50; CFGOUT_n falls only at FCS_n rise.
    wr_begin(6'h11, 8'h50, 1);
    chk("cfg1_cfgout_mid", {31'd0, CFGOUT_n}, 32'h1);
    chk("cfg1_cur_mid", {30'd0, cur_board}, 32'h2);
    wr_end();
    chk("cfg1_cfgout_end", {31'd0, CFGOUT_n}, 32'h0);
    chk("cfg1_configured", {30'd0, configured}, 32'h3);
    rd(7'h00, d, a);
    chk("all_done_ac", {31'd0, a}, 32'h0);

    decode(8'h4F, 2'b01, "sel_4F");
    decode(8'h55, 2'b10, "sel_55");
    decode(8'h60, 2'b00, "sel_60");
    decode(8'h3F, 2'b00, "sel_3F");
    @(negedge CLK);
    cfg_space = 1'b1;
    #1;
    chk("sel_cfgspace", {30'd0, board_sel}, 32'h0);
    cfg_space = 1'b0;

    // Invalid FC removes the select after two clock edges.
    @(negedge CLK);
    ADDRH = 8'h4F;
    FC    = 3'b000;
    @(posedge CLK); #1;
    chk("fc_lat_1clk", {30'd0, board_sel}, 32'h1);
    @(posedge CLK); #1;
    chk("fc_lat_2clk", {30'd0, board_sel}, 32'h0);
    @(negedge CLK);
    FC = 3'b010;
    repeat (2) @(posedge CLK); #1;
    chk("fc_valid_again", {30'd0, board_sel}, 32'h1);

    // Asynchronous reset mid-cycle with everything configured.
    @(posedge CLK);
    #3 RESET_n = 1'b0;
    #1;
    chk("arst_cfgout", {31'd0, CFGOUT_n}, 32'h1);
    chk("arst_configured", {30'd0, configured}, 32'h0);
    chk("arst_cur", {30'd0, cur_board}, 32'h0);
    chk("arst_sel", {30'd0, board_sel}, 32'h0);
    chk("arst_dout", {28'd0, DOUT}, 32'h0);
    @(negedge CLK);
    RESET_n = 1'b1;
    repeat (3) @(posedge CLK);
    rd(7'h01, d, a);
    chk("reoffer_b0_idx01", {28'd0, d}, 32'hC);

    // Shut up board 0, configure board 1.
    wr(6'h13, 8'h40, 1);
    chk("shut0_cur", {30'd0, cur_board}, 32'h1);
    chk("shut0_configured", {30'd0, configured}, 32'h0);
    chk("shut0_cfgout", {31'd0, CFGOUT_n}, 32'h1);
    wr(6'h11, 8'h50, 1);
    chk("shut_cfg1_cfgout", {31'd0, CFGOUT_n}, 32'h0);
    chk("shut_cfg1_configured", {30'd0, configured}, 32'h2);
    decode(8'h4F, 2'b00, "shut_sel_4F");
    decode(8'hFF, 2'b00, "shut_sel_FF");
    decode(8'h55, 2'b10, "shut_sel_55");

    // Long data strobe commits once; unknown offsets are ignored.
    do_reset();
    wr(6'h11, 8'h40, 4);
    chk("long_ds_cur", {30'd0, cur_board}, 32'h1);
    chk("long_ds_configured", {30'd0, configured}, 32'h1);
    wr(6'h05, 8'h99, 1);
    chk("ignored_off_cur", {30'd0, cur_board}, 32'h1);
    chk("ignored_off_configured", {30'd0, configured}, 32'h1);

    // Overlapping bases: lowest index wins.
    wr(6'h11, 8'h40, 1);
    decode(8'h45, 2'b01, "overlap_45");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
